rx_chain_dig: RTL
=================

# rx_chain_dig

Receive-side counterpart of the digital-GPIO transmit split. It takes the decimated I/Q sample stream from an RX chain plus two raw GPIO input pins, and inserts the pins' values into bit 0 of I and Q. Sits between the RX decimator output and the RX FIFO packer. Pin sampling is synchronized, delay-compensated against the analog path, and captured on the sample strobe.

## Interface

Parameters:
- MAX_DELAY, 15, deepest programmable pin delay in clocks; delay line depth.
- DLY_W, 4, width of `dig_delay`; must satisfy 2**DLY_W > MAX_DELAY.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = insert digital bits; 0 = pass samples through unmodified.
- dig_delay  in  DLY_W  pin delay in clocks, 0..MAX_DELAY; values above MAX_DELAY saturate to MAX_DELAY.
- strobe_in  in  1  one-cycle pulse, i_in/q_in valid.
- i_in, q_in  in  16 each  decimated samples.
- i_in_dig, q_in_dig  in  1 each  raw asynchronous GPIO pins.
- i_out, q_out  out  16 each  merged samples.
- strobe_out  out  1  one-cycle pulse, i_out/q_out valid.

## Operation

- Per channel: 2-flop synchronizer (`s1 <= pin; s2 <= s1`), then a shift line `dl[0] <= s2; dl[k] <= dl[k-1]`, k < MAX_DELAY.
- Tap: `s2` when dig_delay == 0, else `dl[dig_delay-1]`.
- On a clock with strobe_in = 1:
  - enable = 1: `i_out <= {i_in[15:1], bit_i}`, `q_out <= {q_in[15:1], bit_q}`.
  - enable = 0: `i_out <= i_in`, `q_out <= q_in`.
- `bit_x` is the tap value in default build; see Configuration.
- When strobe_in = 0, i_out/q_out hold their value.
- `strobe_out <= strobe_in` every clock.
- The synchronizer and delay line run continuously, regardless of enable and strobe.
- A dig_delay change takes effect on the next clock. There is no flush, so the line's existing contents are reused.
- Back-to-back strobes are supported: one output per input, with no gaps added.

## Timing

- Reset (reset = 0, asynchronous): i_out = 0, q_out = 0, strobe_out = 0; synchronizer, delay line and accumulators clear to 0.
- First valid capture is the first strobe_in after reset deasserts. The delay line holds zeros until filled.
- Sample latency: 1 clock (strobe_in at edge E gives strobe_out and data valid after edge E).
- Digital bit captured at edge E equals the pin level sampled at edge E−2−dig_delay (default build).
- Reset asserted mid-stream aborts any pending output; strobe_out is low until strobe_in is seen after release.

## Configuration

- `RX_CHAIN_DIG_STICKY_EN`:
  - Defined: per channel, a sticky accumulator `acc` is set whenever the tap = 1.
  - At a strobe_in capture, `bit_x = tap | acc`, and `acc` clears to 0 on the same edge. A tap = 1 on the capture clock is reported in this sample and not carried over.
  - `acc` is held at 0 while enable = 0. It therefore reports "pin was high at any point since the previous sample", so short pulses between strobes are not lost.
- Undefined: no accumulator; `bit_x` = tap (point sample).

## Structure

- Shared package/include `gpio_dig_pkg`: MAX_DELAY default, DLY_W default, reset level constant for the delay line. The TX split block uses the same constants.
- One sub-module, `dig_sync_delay`: synchronizer, delay line, tap mux and (optional) sticky accumulator for one pin. It is instantiated twice, for I and Q.
- The top level holds the output registers and the enable mux.

## Test plan

- Reset: hold reset = 0 with random inputs -> outputs 0, strobe_out 0; release, strobe_in with i_in = 16'h1235, enable = 1, pins low -> i_out = 16'h1234 one clock later.
- Bypass: enable = 0, i_in = 16'hABCD, q_in = 16'h0001, pins = 1 -> i_out = 16'hABCD, q_out = 16'h0001.
- Delay alignment: dig_delay = 5, i_in_dig pulse high for exactly edge N, strobe_in at edge N+7 -> i_out[0] = 1. Strobe at N+6 or N+8 -> 0.
- Saturation and change: dig_delay = 15 then 4'hF -> tap equals pin at E−17. Switch dig_delay 15→0 mid-stream -> next strobe reports pin at E−2; no X, no glitch on strobe_out.
- Back-to-back: strobe_in high 8 consecutive clocks with incrementing i_in -> 8 consecutive strobe_out, data in order, each LSB = delayed pin.
- Sticky (macro defined): strobes every 10 clocks, one 1-clock q_in_dig pulse between them -> only the next sample has q_out[0] = 1. Same stimulus without the macro and no strobe aligned to the pulse -> q_out[0] = 0.

Source files
------------

// File: rtl/gpio_dig_pkg.sv
// Constants shared by the RX and TX digital-GPIO blocks: default delay-line
// geometry, sample width and the level the pin pipeline resets to.
package gpio_dig_pkg;

  localparam int   MAX_DELAY_DEF = 15;
  localparam int   DLY_W_DEF     = 4;
  localparam int   SAMPLE_W      = 16;
  localparam logic DL_RST_LEVEL  = 1'b0;

  typedef struct packed {
    logic [SAMPLE_W-1:0] i;
    logic [SAMPLE_W-1:0] q;
  } iq_sample_t;

endpackage

// File: rtl/dig_sync_delay.sv
// One GPIO pin: 2-flop synchronizer, programmable delay line and tap mux.
// Optional sticky accumulator enabled by RX_CHAIN_DIG_STICKY_EN.
module dig_sync_delay
  import gpio_dig_pkg::*;
#(
  parameter int MAX_DELAY = MAX_DELAY_DEF,
  parameter int DLY_W     = DLY_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
`ifdef RX_CHAIN_DIG_STICKY_EN
  input  logic             enable,
  input  logic             strobe,
`endif
  input  logic [DLY_W-1:0] dig_delay,
  input  logic             pin,
  output logic             bit_out
);

  logic             s1_reg;
  logic             s2_reg;
  logic             dl_reg [MAX_DELAY];
  logic [DLY_W-1:0] dly_sat;
  logic             tap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_reg <= DL_RST_LEVEL;
      s2_reg <= DL_RST_LEVEL;
    end else begin
      s1_reg <= pin;
      s2_reg <= s1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_DELAY; gi++) begin : g_dl
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          dl_reg[gi] <= DL_RST_LEVEL;
        end else if (gi == 0) begin
          dl_reg[gi] <= s2_reg;
        end else begin
          dl_reg[gi] <= dl_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  // Out-of-range delays clamp to the deepest tap instead of wrapping.
  always_comb begin
    dly_sat = (dig_delay > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : dig_delay;
    tap     = s2_reg;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (dly_sat == DLY_W'(k + 1)) begin
        tap = dl_reg[k];
      end
    end
  end

`ifdef RX_CHAIN_DIG_STICKY_EN
  logic acc_reg;

  // Remembers any high tap since the last capture; the capture edge consumes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_reg <= 1'b0;
    end else if (!enable || strobe) begin
      acc_reg <= 1'b0;
    end else if (tap) begin
      acc_reg <= 1'b1;
    end
  end

  assign bit_out = tap | acc_reg;
`else
  assign bit_out = tap;
`endif

endmodule

// File: rtl/rx_chain_dig.sv
// Merges two delay-compensated GPIO pins into bit 0 of the decimated I/Q stream.
// Build option: RX_CHAIN_DIG_STICKY_EN (pin reported high if seen since last sample).
module rx_chain_dig
  import gpio_dig_pkg::*;
#(
  parameter int MAX_DELAY = MAX_DELAY_DEF,
  parameter int DLY_W     = DLY_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [DLY_W-1:0]    dig_delay,
  input  logic                strobe_in,
  input  logic [SAMPLE_W-1:0] i_in,
  input  logic [SAMPLE_W-1:0] q_in,
  input  logic                i_in_dig,
  input  logic                q_in_dig,
  output logic [SAMPLE_W-1:0] i_out,
  output logic [SAMPLE_W-1:0] q_out,
  output logic                strobe_out
);

  logic [1:0]          pin_vec;
  logic [1:0]          bit_vec;
  logic [SAMPLE_W-1:0] i_next;
  logic [SAMPLE_W-1:0] q_next;
  logic [SAMPLE_W-1:0] i_reg;
  logic [SAMPLE_W-1:0] q_reg;
  logic                strobe_reg;

  // Index 0 carries the I pin, index 1 the Q pin.
  assign pin_vec = {q_in_dig, i_in_dig};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      dig_sync_delay #(
        .MAX_DELAY (MAX_DELAY),
        .DLY_W     (DLY_W)
      ) u_sync_delay (
        .clock     (clock),
        .reset     (reset),
`ifdef RX_CHAIN_DIG_STICKY_EN
        .enable    (enable),
        .strobe    (strobe_in),
`endif
        .dig_delay (dig_delay),
        .pin       (pin_vec[gi]),
        .bit_out   (bit_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    i_next = i_in;
    q_next = q_in;
    if (enable) begin
      i_next = {i_in[SAMPLE_W-1:1], bit_vec[0]};
      q_next = {q_in[SAMPLE_W-1:1], bit_vec[1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_reg      <= '0;
      q_reg      <= '0;
      strobe_reg <= 1'b0;
    end else begin
      strobe_reg <= strobe_in;
      if (strobe_in) begin
        i_reg <= i_next;
        q_reg <= q_next;
      end
    end
  end

  assign i_out      = i_reg;
  assign q_out      = q_reg;
  assign strobe_out = strobe_reg;

endmodule
